lidar_point_packer: RTL and testbench
=====================================

# lidar_point_packer

Upstream ingest stage for the LiDAR feature extractor. It accepts a stream of 128-bit LiDAR points over a valid/ready handshake and drops points outside a configurable range. Surviving points are packed four at a time into the extractor's 512-bit `point_cloud` input. For each packed frame it runs the extractor's `start`/`done` handshake and holds `point_cloud` stable until the extractor releases it.

## Interface
Parameters:
- `RANGE_MAX`, default 32'd100000: maximum absolute coordinate value kept, signed-32 compare, inclusive.
- `TIMEOUT_CYCLES`, default 1048576: cycles to wait for `ext_done` before aborting a frame.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pt_valid`  in  1  input point valid.
- `pt_ready`  out  1  block can accept a point.
- `pt_data`  in  128  point: [127:96] x, [95:64] y, [63:32] z (signed 32), [31:0] intensity (unsigned).
- `pt_last`  in  1  marks the final point of a scan; closes the frame early.
- `ext_start`  out  1  start to the feature extractor.
- `ext_done`  in  1  done from the feature extractor.
- `point_cloud`  out  512  packed frame; point k in [k*128 +: 128], k = 0..3.
- `frame_pts`  out  3  number of valid points in `point_cloud` (1..4).
- `drop_count`  out  16  points rejected by the range filter; saturates at 16'hFFFF.
- `frame_count`  out  16  frames completed with `ext_done`; wraps.
- `timeout_err`  out  1  sticky; set on timeout, cleared only by reset.
- `busy`  out  1  high in LAUNCH or RELEASE.

## Operation
- States: FILL, LAUNCH, RELEASE.
- Reset values: state FILL, all outputs 0.
  - `point_cloud` = 0.
  - `pt_ready` = 0 while `rst_n` is low; `pt_ready` = 1 from the first clock after reset deassertion.
- FILL:
  - `pt_ready` = 1.
  - Accept occurs when `pt_valid & pt_ready`.
- Range filter: a point is kept iff |x|, |y| and |z| are each <= `RANGE_MAX`.
  - The value -2^31 always counts as out of range.
  - Intensity is not checked.
- Kept point: written into slot `fill_idx`, then `fill_idx` increments (2-bit slot index, 3-bit count).
- Dropped point: `drop_count` increments (saturating); no slot is written.
- Frame close: triggered by an accept that makes the kept count 4, or by any accept with `pt_last` = 1, whether that point is kept or dropped.
  - Close with kept count >= 1: `frame_pts` = count, go to LAUNCH.
  - Close with kept count 0 (`pt_last` on a dropped point, nothing kept): no launch, stay in FILL, nothing else changes.
- Unused slots in a partial frame read as zero. The buffer is cleared to zero on every entry to FILL.
- LAUNCH:
  - `pt_ready` = 0, `ext_start` = 1.
  - `point_cloud` and `frame_pts` are frozen.
  - On `ext_done` = 1: `frame_count` increments, go to RELEASE.
  - If the timeout counter reaches `TIMEOUT_CYCLES` - 1 without `ext_done`: set `timeout_err`, do not increment `frame_count`, go to RELEASE.
- RELEASE:
  - `ext_start` = 0.
  - Wait for `ext_done` = 0 (the extractor returns to IDLE when start drops).
  - Then go to FILL, clear the buffer and counts.
- Simultaneous events: a `pt_last` accept that is also the 4th kept point closes exactly one frame.
- Reset mid-operation: from any state, an immediate return to reset values. `ext_start` drops asynchronously.

## Timing
- All outputs are registered.
- Accept on cycle N is visible in `point_cloud` on cycle N+1.
- Closing accept on cycle N: `ext_start` = 1 and `pt_ready` = 0 from cycle N+1.
- `ext_done` sampled high on cycle M: `ext_start` = 0 and `frame_count` updated on M+1.
- `ext_done` sampled low in RELEASE on cycle R: `pt_ready` = 1 on R+1, with buffer already zero.
- Minimum frame turnaround: 4 accepts + 1 LAUNCH cycle + 1 RELEASE cycle.
- Timeout counter:
  - Counts LAUNCH cycles, starting at 0 on entry.
  - Asserts `timeout_err` on the cycle after the count reaches `TIMEOUT_CYCLES` - 1.
- `pt_data` and `pt_last` are ignored whenever `pt_ready` = 0.

## Test plan
- Four in-range points with x = 1, 2, 3, 4 (others 0), back-to-back:
  - `point_cloud` = {p3, p2, p1, p0}, `frame_pts` = 4.
  - `ext_start` rises the cycle after the 4th accept; `pt_ready` = 0.
- Two kept points, then `pt_last` on the 2nd:
  - `frame_pts` = 2, `point_cloud[511:256]` = 0, LAUNCH entered.
- Point with x = 32'h8000_0000, then a point with z = `RANGE_MAX` + 1:
  - `drop_count` = 2, no slot written.
  - A point with z = `RANGE_MAX` is kept.
- `ext_done` pulsed high 10 cycles after `ext_start`, then low 3 cycles later:
  - `ext_start` falls the next cycle; `frame_count` = 1.
  - `pt_ready` = 1 the cycle after `ext_done` falls; `point_cloud` = 0.
- Bench with `TIMEOUT_CYCLES` = 16 and `ext_done` held 0:
  - `timeout_err` = 1 after 16 LAUNCH cycles; `frame_count` unchanged; return to FILL.
- `rst_n` asserted while in LAUNCH:
  - `ext_start`, `point_cloud`, `drop_count` and `frame_count` = 0 immediately.
  - `pt_ready` = 1 on the first clock after release.

Source files
------------

// File: rtl/lidar_point_packer.sv
// Range-filters a stream of 128-bit LiDAR points and packs survivors four at a time
// into a 512-bit frame, then runs the extractor's start/done handshake for that frame.
`timescale 1ns/1ps

module lidar_point_packer #(
    parameter logic [31:0] RANGE_MAX      = 32'd100000,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [127:0] pt_data,
    input  logic         pt_last,
    output logic         ext_start,
    input  logic         ext_done,
    output logic [511:0] point_cloud,
    output logic [2:0]   frame_pts,
    output logic [15:0]  drop_count,
    output logic [15:0]  frame_count,
    output logic         timeout_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        RELEASE
    } state_e;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e         state_q;
    logic [127:0]   buf_q [4];
    logic [2:0]     fill_cnt_q;
    logic [2:0]     frame_pts_q;
    logic [15:0]    drop_count_q;
    logic [15:0]    frame_count_q;
    logic [TW-1:0]  tmo_cnt_q;
    logic           pt_ready_q;
    logic           ext_start_q;
    logic           timeout_err_q;
    logic           busy_q;

    // -2^31 has no positive magnitude in 32 bits, so it is rejected outright.
    function automatic logic coord_ok(input logic [31:0] v);
        logic [31:0] mag;
        mag = v[31] ? (~v + 32'd1) : v;
        return (v != 32'h8000_0000) && ($signed(mag) <= $signed(RANGE_MAX));
    endfunction

    logic       accept;
    logic       keep;
    logic [2:0] kept_cnt;
    logic       close;

    always_comb begin
        accept   = pt_valid && pt_ready_q && (state_q == FILL);
        keep     = coord_ok(pt_data[127:96]) && coord_ok(pt_data[95:64])
                   && coord_ok(pt_data[63:32]);
        kept_cnt = fill_cnt_q + {2'b00, keep};
        close    = accept && (pt_last || (kept_cnt == 3'd4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            // NOTE: the frame buffer is reset because it drives point_cloud directly,
            // which must read zero out of reset; pure storage would not need this.
            for (int k = 0; k < 4; k++) buf_q[k] <= '0;
            fill_cnt_q    <= '0;
            frame_pts_q   <= '0;
            drop_count_q  <= '0;
            frame_count_q <= '0;
            tmo_cnt_q     <= '0;
            pt_ready_q    <= 1'b0;
            ext_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    // NOTE: the default here is overridden by the later close branch;
                    // with non-blocking assignments the last one in the block wins.
                    pt_ready_q <= 1'b1;
                    if (accept) begin
                        if (keep) begin
                            buf_q[fill_cnt_q[1:0]] <= pt_data;
                            fill_cnt_q             <= kept_cnt;
                        end else if (drop_count_q != 16'hFFFF) begin
                            drop_count_q <= drop_count_q + 16'd1;
                        end
                        // A pt_last on an empty frame closes nothing.
                        if (close && (kept_cnt != 3'd0)) begin
                            state_q     <= LAUNCH;
                            frame_pts_q <= kept_cnt;
                            pt_ready_q  <= 1'b0;
                            ext_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            tmo_cnt_q   <= '0;
                        end
                    end
                end
                LAUNCH: begin
                    if (ext_done) begin
                        frame_count_q <= frame_count_q + 16'd1;
                        ext_start_q   <= 1'b0;
                        state_q       <= RELEASE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        ext_start_q   <= 1'b0;
                        state_q       <= RELEASE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                RELEASE: begin
                    if (!ext_done) begin
                        state_q     <= FILL;
                        pt_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        fill_cnt_q  <= '0;
                        frame_pts_q <= '0;
                        for (int k = 0; k < 4; k++) buf_q[k] <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign point_cloud = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
    assign pt_ready    = pt_ready_q;
    assign ext_start   = ext_start_q;
    assign frame_pts   = frame_pts_q;
    assign drop_count  = drop_count_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lidar_point_packer.sv
// Directed bench for lidar_point_packer: packing, range filter, handshake, timeout, reset.
`timescale 1ns/1ps

module tb_lidar_point_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [127:0] pt_data = '0;
    logic         pt_last = 1'b0;
    logic         ext_start;
    logic         ext_done = 1'b0;
    logic [511:0] point_cloud;
    logic [2:0]   frame_pts;
    logic [15:0]  drop_count;
    logic [15:0]  frame_count;
    logic         timeout_err;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    logic [511:0] exp_cloud;

    always #5 clk = ~clk;

    lidar_point_packer #(
        .RANGE_MAX      (32'd100000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_data     (pt_data),
        .pt_last     (pt_last),
        .ext_start   (ext_start),
        .ext_done    (ext_done),
        .point_cloud (point_cloud),
        .frame_pts   (frame_pts),
        .drop_count  (drop_count),
        .frame_count (frame_count),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    function automatic logic [127:0] mkpt(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic [31:0] i);
        return {x, y, z, i};
    endfunction

    // Starts and ends on a falling edge; the rising edge in between is the accept.
    task automatic send(input logic [127:0] d, input logic last);
        pt_valid = 1'b1;
        pt_data  = d;
        pt_last  = last;
        @(negedge clk);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        pt_data  = '0;
    endtask

    task automatic finish_frame();
        ext_done = 1'b1;
        @(negedge clk);
        ext_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (pt_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pt_ready: got %b want 0", pt_ready); end
        vectors++; if (ext_start !== 1'b0) begin miscompares++; $display("FAIL reset_ext_start: got %b want 0", ext_start); end
        vectors++; if (point_cloud !== 512'd0) begin miscompares++; $display("FAIL reset_point_cloud: got %h want 0", point_cloud); end
        vectors++; if ({frame_pts, drop_count, frame_count, timeout_err, busy} !== 37'd0) begin
            miscompares++; $display("FAIL reset_counters: got pts=%0d drop=%0d frames=%0d tmo=%b busy=%b want all 0",
                                    frame_pts, drop_count, frame_count, timeout_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (pt_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", pt_ready); end
    endtask

    task automatic test_pack4();
        logic [127:0] p [4];
        for (int k = 0; k < 4; k++) p[k] = mkpt(32'(k + 1), 32'd0, 32'd0, 32'(256 + k));
        exp_cloud = {p[3], p[2], p[1], p[0]};
        send(p[0], 1'b0);
        vectors++; if (point_cloud !== {384'd0, p[0]}) begin miscompares++; $display("FAIL pack4_first_slot: got %h want %h", point_cloud, {384'd0, p[0]}); end
        send(p[1], 1'b0);
        send(p[2], 1'b0);
        send(p[3], 1'b0);
        vectors++; if (ext_start !== 1'b1) begin miscompares++; $display("FAIL pack4_ext_start: got %b want 1", ext_start); end
        vectors++; if (pt_ready !== 1'b0) begin miscompares++; $display("FAIL pack4_pt_ready: got %b want 0", pt_ready); end
        vectors++; if (frame_pts !== 3'd4) begin miscompares++; $display("FAIL pack4_frame_pts: got %0d want 4", frame_pts); end
        vectors++; if (point_cloud !== exp_cloud) begin miscompares++; $display("FAIL pack4_cloud: got %h want %h", point_cloud, exp_cloud); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pack4_busy: got %b want 1", busy); end
    endtask

    task automatic test_ext_done();
        // An out-of-range point offered during LAUNCH must be ignored entirely.
        pt_valid = 1'b1;
        pt_data  = mkpt(32'h8000_0000, 32'd0, 32'd0, 32'd0);
        pt_last  = 1'b1;
        repeat (9) @(negedge clk);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        pt_data  = '0;
        vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL launch_ignores_input: drop_count got %0d want 0", drop_count); end
        vectors++; if (point_cloud !== exp_cloud) begin miscompares++; $display("FAIL launch_cloud_frozen: got %h want %h", point_cloud, exp_cloud); end
        ext_done = 1'b1;
        @(negedge clk);
        vectors++; if (ext_start !== 1'b0) begin miscompares++; $display("FAIL done_ext_start_fall: got %b want 0", ext_start); end
        vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL done_frame_count: got %0d want 1", frame_count); end
        repeat (2) @(negedge clk);
        vectors++; if (pt_ready !== 1'b0) begin miscompares++; $display("FAIL release_holds: pt_ready got %b want 0", pt_ready); end
        vectors++; if (point_cloud !== exp_cloud) begin miscompares++; $display("FAIL release_cloud_held: got %h want %h", point_cloud, exp_cloud); end
        ext_done = 1'b0;
        @(negedge clk);
        vectors++; if (pt_ready !== 1'b1) begin miscompares++; $display("FAIL release_pt_ready: got %b want 1", pt_ready); end
        vectors++; if (point_cloud !== 512'd0) begin miscompares++; $display("FAIL release_cloud_clear: got %h want 0", point_cloud); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic test_partial();
        logic [127:0] a, b;
        a = mkpt(32'd5, 32'd0, 32'd0, 32'hAAAA);
        b = mkpt(32'd6, 32'd0, 32'd0, 32'hBBBB);
        send(a, 1'b0);
        send(b, 1'b1);
        vectors++; if (frame_pts !== 3'd2) begin miscompares++; $display("FAIL partial_frame_pts: got %0d want 2", frame_pts); end
        vectors++; if (point_cloud[511:256] !== 256'd0) begin miscompares++; $display("FAIL partial_upper_zero: got %h want 0", point_cloud[511:256]); end
        vectors++; if (point_cloud[255:0] !== {b, a}) begin miscompares++; $display("FAIL partial_lower: got %h want %h", point_cloud[255:0], {b, a}); end
        vectors++; if (ext_start !== 1'b1) begin miscompares++; $display("FAIL partial_launch: ext_start got %b want 1", ext_start); end
        finish_frame();
        vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL partial_frame_count: got %0d want 2", frame_count); end
        vectors++; if (pt_ready !== 1'b1) begin miscompares++; $display("FAIL partial_back_to_fill: pt_ready got %b want 1", pt_ready); end
    endtask

    task automatic test_range_filter();
        logic [127:0] kz, ky;
        logic [31:0]  neg_max, neg_over;
        neg_max  = -32'sd100000;
        neg_over = -32'sd100001;
        kz = mkpt(32'd0, 32'd0, 32'd100000, 32'd3);
        ky = mkpt(32'd0, neg_max, 32'd0, 32'd4);
        send(mkpt(32'h8000_0000, 32'd0, 32'd0, 32'd1), 1'b0);
        send(mkpt(32'd0, 32'd0, 32'd100001, 32'd2), 1'b1);
        vectors++; if (drop_count !== 16'd2) begin miscompares++; $display("FAIL drop_count_two: got %0d want 2", drop_count); end
        vectors++; if (point_cloud !== 512'd0) begin miscompares++; $display("FAIL drop_no_slot: got %h want 0", point_cloud); end
        vectors++; if ({ext_start, pt_ready} !== 2'b01) begin miscompares++; $display("FAIL empty_last_no_launch: ext_start,pt_ready got %b want 01", {ext_start, pt_ready}); end
        send(kz, 1'b0);
        vectors++; if (point_cloud !== {384'd0, kz}) begin miscompares++; $display("FAIL keep_z_at_max: got %h want %h", point_cloud, {384'd0, kz}); end
        send(ky, 1'b0);
        send(mkpt(32'd0, neg_over, 32'd0, 32'd5), 1'b1);
        vectors++; if (drop_count !== 16'd3) begin miscompares++; $display("FAIL drop_neg_over: got %0d want 3", drop_count); end
        vectors++; if (frame_pts !== 3'd2) begin miscompares++; $display("FAIL last_on_drop_pts: got %0d want 2", frame_pts); end
        vectors++; if (point_cloud !== {256'd0, ky, kz}) begin miscompares++; $display("FAIL last_on_drop_cloud: got %h want %h", point_cloud, {256'd0, ky, kz}); end
        vectors++; if (ext_start !== 1'b1) begin miscompares++; $display("FAIL last_on_drop_launch: ext_start got %b want 1", ext_start); end
        finish_frame();
        vectors++; if (frame_count !== 16'd3) begin miscompares++; $display("FAIL filter_frame_count: got %0d want 3", frame_count); end
    endtask

    task automatic test_timeout();
        send(mkpt(32'd7, 32'd0, 32'd0, 32'd0), 1'b1);
        repeat (15) @(negedge clk);
        vectors++; if ({timeout_err, ext_start} !== 2'b01) begin miscompares++; $display("FAIL timeout_early: tmo,ext_start got %b want 01", {timeout_err, ext_start}); end
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
        vectors++; if (ext_start !== 1'b0) begin miscompares++; $display("FAIL timeout_ext_start: got %b want 0", ext_start); end
        vectors++; if (frame_count !== 16'd3) begin miscompares++; $display("FAIL timeout_frame_count: got %0d want 3", frame_count); end
        @(negedge clk);
        vectors++; if ({pt_ready, timeout_err} !== 2'b11) begin miscompares++; $display("FAIL timeout_return: pt_ready,tmo got %b want 11", {pt_ready, timeout_err}); end
        vectors++; if (point_cloud !== 512'd0) begin miscompares++; $display("FAIL timeout_cloud_clear: got %h want 0", point_cloud); end
    endtask

    task automatic test_reset_in_launch();
        send(mkpt(32'd9, 32'd0, 32'd0, 32'd0), 1'b1);
        vectors++; if (ext_start !== 1'b1) begin miscompares++; $display("FAIL rst_pre_launch: ext_start got %b want 1", ext_start); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (ext_start !== 1'b0) begin miscompares++; $display("FAIL rst_async_ext_start: got %b want 0", ext_start); end
        vectors++; if (point_cloud !== 512'd0) begin miscompares++; $display("FAIL rst_async_cloud: got %h want 0", point_cloud); end
        vectors++; if ({drop_count, frame_count, timeout_err, pt_ready} !== 34'd0) begin
            miscompares++; $display("FAIL rst_async_regs: got drop=%0d frames=%0d tmo=%b ready=%b want all 0",
                                    drop_count, frame_count, timeout_err, pt_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if ({pt_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL rst_release_ready: pt_ready,busy got %b want 10", {pt_ready, busy}); end
    endtask

    initial begin
        test_reset();
        test_pack4();
        test_ext_done();
        test_partial();
        test_range_filter();
        test_timeout();
        test_reset_in_launch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
